// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the multicycle memory responder.
// State encoding, error codes, default latency and statistics counter helpers.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_CONFLICT = 2'b11;

    localparam int DEF_LATENCY = 2;
    localparam int CNT_W       = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Word RAM, 2^ADDR_W x 32: synchronous write, combinational read, no reset.
// Zero-latency read; no backpressure, the write strobe is trusted as-is.
module mem_resp_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder for a multicycle CPU: latches one request, answers LATENCY+1 cycles later.
// Backpressure: requests are only sampled in IDLE; busy is high from accept through the response cycle.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             inst_data,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             ready,
    output logic             busy,
    output logic [1:0]       err,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic             w_accept;
    logic             w_resp;

    logic             r_rd;
    logic             r_wr;
    logic             r_id;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;

    logic [31:0]      r_rdata;
    logic             r_ready;
    logic             r_busy;
    logic [1:0]       r_err;
    logic [CNT_W-1:0] r_fetch_cnt;
    logic [CNT_W-1:0] r_rd_cnt;
    logic [CNT_W-1:0] r_wr_cnt;

    logic [1:0]       w_err;
    logic             w_ok;
    logic             w_we;
    logic [31:0]      w_arr_rdata;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_resp      = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = 4'(LATENCY);
                    w_state_nxt = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                // <= 1 also guards against a stray zero count
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RESP: begin
                w_resp      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        if (r_rd && r_wr) begin
            w_err = ERR_CONFLICT;
        end else if (r_addr[1:0] != 2'b00) begin
            w_err = ERR_MISALIGN;
        end else if ((r_addr >> (ADDR_W + 2)) != 32'd0) begin
            w_err = ERR_RANGE;
        end else begin
            w_err = ERR_OK;
        end
    end

    assign w_ok = (w_err == ERR_OK);
    // state is async-reset, so no write can slip through while reset is low
    assign w_we = w_resp && r_wr && w_ok;

    mem_resp_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (r_addr[ADDR_W+1:2]),
        .i_wdata (r_wdata),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_id    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else if (w_accept) begin
            r_rd    <= mem_read;
            r_wr    <= mem_write;
            r_id    <= inst_data;
            r_addr  <= addr;
            r_wdata <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata     <= 32'd0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= ERR_OK;
            r_fetch_cnt <= '0;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
        end else begin
            r_ready <= w_resp;
            r_err   <= w_resp ? w_err : ERR_OK;
            r_busy  <= (w_state_nxt != IDLE) || w_resp;
            if (w_resp) begin
                if (!w_ok) begin
                    r_rdata <= 32'd0;
                end else if (r_rd) begin
                    r_rdata <= w_arr_rdata;
                end
                if (w_ok) begin
                    if (r_wr) begin
                        r_wr_cnt <= sat_inc(r_wr_cnt);
                    end else if (r_id) begin
                        r_rd_cnt <= sat_inc(r_rd_cnt);
                    end else begin
                        r_fetch_cnt <= sat_inc(r_fetch_cnt);
                    end
                end
            end
        end
    end

    assign rdata     = r_rdata;
    assign ready     = r_ready;
    assign busy      = r_busy;
    assign err       = r_err;
    assign fetch_cnt = r_fetch_cnt;
    assign rd_cnt    = r_rd_cnt;
    assign wr_cnt    = r_wr_cnt;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; array depth is 2^ADDR_W 32-bit words.
REQ-002 Parameter LATENCY, default 2, wait cycles between request accept and response; legal range 0..15.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1, rising-edge clock.
REQ-005 Port reset, input, 1, asynchronous active-low reset.
REQ-006 Port mem_read, input, 1, read request level from the multicycle controller.
REQ-007 Port mem_write, input, 1, write request level from the multicycle controller.
REQ-008 Port inst_data, input, 1, 0 = instruction fetch (PC address), 1 = data access (ALU address).
REQ-009 Port addr, input, 32, byte address.
REQ-010 Port wdata, input, 32, store data.
REQ-011 Port rdata, output, 32, read data; held between responses.
REQ-012 Port ready, output, 1, one-cycle response strobe.
REQ-013 Port busy, output, 1, high from accept through the response cycle.
REQ-014 Port err, output, 2, response error code, valid with ready: 00 ok, 01 misaligned, 10 out of range, 11 conflict.
REQ-015 Port fetch_cnt / rd_cnt / wr_cnt, output, 16 each, saturating completed-access counters.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, and RESP; at reset it SHALL be in IDLE.
REQ-017 IDLE: if mem_read or mem_write is 1 at a clock edge, the block SHALL accept the request.
- Accept latches mem_read, mem_write, inst_data, addr, and wdata.
- Accept sets busy.
- Next state is WAIT with count = LATENCY, or RESP directly when LATENCY = 0.
REQ-018 WAIT SHALL decrement its count each cycle and go to RESP when the count reaches 1; ready SHALL assert exactly LATENCY+1 cycles after the accept edge.
REQ-019 During WAIT/RESP, input changes SHALL be ignored, and only latched values SHALL be used.
REQ-020 RESP SHALL assert ready for one cycle and then return to IDLE; busy SHALL drop in the following cycle.
REQ-021 A request level still high in IDLE after RESP SHALL be treated as a new request; back-to-back reads are legal.
REQ-022 A read in RESP SHALL drive rdata = array[addr[ADDR_W+1:2]]; rdata SHALL hold until the next successful read response.
REQ-023 A write SHALL commit to the array on the RESP edge only; rdata SHALL be unchanged by writes.
REQ-024 Error checks SHALL apply in priority order:
- conflict: mem_read and mem_write both 1.
- misaligned: addr[1:0] != 0.
- out of range: addr[31:ADDR_W+2] != 0.
REQ-025 An errored request SHALL still complete with ready and the error code, SHALL NOT write, SHALL NOT count, and SHALL force rdata = 0.
REQ-026 On a successful response, the block SHALL increment one counter:
- fetch_cnt when it is a read with inst_data = 0.
- rd_cnt when it is a read with inst_data = 1.
- wr_cnt when it is a write.
REQ-027 Counters SHALL saturate at 16'hFFFF with no wrap.
REQ-028 err SHALL be 00 in every cycle where ready is 0.

Reset
REQ-029 On reset low, the FSM SHALL go immediately to IDLE, and all outputs SHALL go to 0: rdata, ready, busy, err, and all counters.
REQ-030 Reset mid-operation SHALL abort the request, and any pending write SHALL NOT commit.
REQ-031 Array contents SHALL NOT be reset.
REQ-032 After reset release, the first edge with a request SHALL be an accept.

Structure
REQ-033 A shared package mem_resp_pkg SHALL hold:
- the state enum IDLE/WAIT/RESP.
- the error-code constants ERR_OK, ERR_MISALIGN, ERR_RANGE, ERR_CONFLICT.
- the default LATENCY.
- the counter width.
REQ-034 The block SHALL use one sub-module, mem_resp_array: a 2^ADDR_W x 32 synchronous-write, combinational-read word RAM with no reset.
REQ-035 FSM, latency counter, error logic, and statistics counters SHALL be in mem_responder.

Verification
REQ-036 The bench SHALL cover these scenarios with LATENCY=2:
- Write then read: write addr 0x10, wdata 0xDEADBEEF, inst_data=1 -> ready 3 cycles after accept, err 00, wr_cnt=1; then read 0x10 -> rdata 0xDEADBEEF, rd_cnt=1.
- Fetch: read addr 0x0 with inst_data=0 after preloading 0x20080005 -> rdata 0x20080005, fetch_cnt=1, rd_cnt unchanged.
- Misaligned: read addr 0x13 -> ready with err 01, rdata 0, counters unchanged.
- Out of range: write addr 0x0000_1000 -> err 10, array unchanged, wr_cnt unchanged.
- Conflict: mem_read=1 and mem_write=1 at addr 0x4 -> err 11, no write.
- Reset mid-write: drop reset during WAIT of a write to 0x8 -> outputs 0, FSM IDLE; a following read of 0x8 returns the old value.
REQ-037 The bench SHALL also run LATENCY=0 and check ready is 1 cycle after accept.
REQ-038 The bench SHALL preload counters near saturation and check they stay at 0xFFFF.
